// File: rtl/tlp_rx_router.sv
// tlp_rx_router: demultiplexes link-layer TLP beats onto AR/AW/RC header
// channels and WR/RC payload channels, with per-TLP beat tracking,
// malformed detection and unsupported-TLP dropping.
module tlp_rx_router #(
  parameter int DATA_WIDTH = 256,  // link-layer pipe width (multiple of 128)
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  ar_hdr_valid,
  input  logic                  ar_hdr_ready,
  output logic [127:0]          ar_hdr_data,
  output logic                  aw_hdr_valid,
  input  logic                  aw_hdr_ready,
  output logic [127:0]          aw_hdr_data,
  output logic                  wr_pay_valid,
  input  logic                  wr_pay_ready,
  output logic [DATA_WIDTH-1:0] wr_pay_data,
  output logic                  wr_pay_last,
  output logic                  rc_hdr_valid,
  input  logic                  rc_hdr_ready,
  output logic [127:0]          rc_hdr_data,
  output logic                  rc_pay_valid,
  input  logic                  rc_pay_ready,
  output logic [DATA_WIDTH-1:0] rc_pay_data,
  output logic                  rc_pay_last,
  output logic                  err_malformed,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  malformed_cnt
);
  // Beat counter covers 16 B header + 4096 B payload at 16 B/beat = 257 beats.
  localparam int         BCW      = 9;
  localparam int         BPB      = DATA_WIDTH / 8;
  // Type codes mirror the link-layer package values.
  localparam logic [4:0] TYPE_MEM = 5'b00000;
  localparam logic [4:0] TYPE_CPL = 5'b01010;

  typedef enum logic [1:0] {S_IDLE, S_WR_PAY, S_RC_PAY, S_DROP} state_t;
  typedef enum logic [2:0] {CL_MRD, CL_MWR, CL_CPLD, CL_CPL, CL_UNS} cls_t;

  state_t                r_state;
  logic [BCW-1:0]        r_cnt, r_exp;
  logic                  r_ar_v, r_aw_v, r_wr_v, r_rch_v, r_rcp_v;
  logic [127:0]          r_ar_d, r_aw_d, r_rch_d;
  logic [DATA_WIDTH-1:0] r_wr_d, r_rcp_d;
  logic                  r_wr_last, r_rcp_last, r_err;
  logic [CNT_WIDTH-1:0]  r_drop_cnt, r_malf_cnt;

  logic [127:0]   w_hdr;
  logic [2:0]     w_fmt;
  logic [4:0]     w_type;
  logic [9:0]     w_len;
  cls_t           w_cls;
  logic           w_has_data;
  logic [10:0]    w_len_dw;
  logic [13:0]    w_bytes, w_exp_full;
  logic [BCW-1:0] w_exp, w_cnt_cur, w_exp_cur, w_cnt_nxt;
  logic           w_idle, w_at_exp, w_pay_last, w_pay_err, w_hs, w_tail;
  logic           w_ar_free, w_aw_free, w_wr_free, w_rch_free, w_rcp_free;
  state_t         w_nxt_state;

  assign w_hdr  = s_data[DATA_WIDTH-1 -: 128];
  assign w_fmt  = w_hdr[127:125];
  assign w_type = w_hdr[124:120];
  assign w_len  = w_hdr[105:96];

  // Classify the first-beat header.
  always_comb begin
    w_cls = CL_UNS;
    if (w_type == TYPE_MEM && w_fmt[2:1] == 2'b00)      w_cls = CL_MRD;
    else if (w_type == TYPE_MEM && w_fmt[2:1] == 2'b01) w_cls = CL_MWR;
    else if (w_type == TYPE_CPL && w_fmt == 3'b010)     w_cls = CL_CPLD;
    else if (w_type == TYPE_CPL && w_fmt == 3'b000)     w_cls = CL_CPL;
  end

  // Beats for this TLP: ceil((header + payload bytes) / bytes-per-beat).
  assign w_has_data = (w_cls == CL_MWR) || (w_cls == CL_CPLD);
  assign w_len_dw   = (w_len == 10'd0) ? 11'd1024 : {1'b0, w_len};
  assign w_bytes    = 14'd16 + (w_has_data ? {1'b0, w_len_dw, 2'b00} : 14'd0);
  assign w_exp_full = (w_bytes + 14'(BPB - 1)) / 14'(BPB);
  assign w_exp      = BCW'(w_exp_full);

  // First beat behaves like beat 1 of a count starting at 0, so IDLE and the
  // payload states share one termination rule.
  assign w_idle     = (r_state == S_IDLE);
  assign w_cnt_cur  = w_idle ? '0 : r_cnt;
  assign w_exp_cur  = w_idle ? w_exp : r_exp;
  assign w_cnt_nxt  = w_cnt_cur + BCW'(1);
  assign w_at_exp   = (w_cnt_nxt == w_exp_cur);
  assign w_pay_last = s_last | w_at_exp;
  assign w_pay_err  = s_last ^ w_at_exp;

  // Next state after a routed beat: early last -> IDLE, missing last -> DROP.
  always_comb begin
    w_nxt_state = r_state;
    if (s_last)        w_nxt_state = S_IDLE;
    else if (w_at_exp) w_nxt_state = S_DROP;
    else if (w_idle)   w_nxt_state = (w_cls == CL_MWR) ? S_WR_PAY : S_RC_PAY;
  end

  assign w_ar_free  = !r_ar_v  || ar_hdr_ready;
  assign w_aw_free  = !r_aw_v  || aw_hdr_ready;
  assign w_wr_free  = !r_wr_v  || wr_pay_ready;
  assign w_rch_free = !r_rch_v || rc_hdr_ready;
  assign w_rcp_free = !r_rcp_v || rc_pay_ready;

  // Accept only when every register the beat lands in can take it this cycle.
  always_comb begin
    s_ready = 1'b1;
    case (r_state)
      S_IDLE: begin
        case (w_cls)
          CL_MRD:  s_ready = w_ar_free;
          CL_MWR:  s_ready = w_aw_free && w_wr_free;
          CL_CPLD: s_ready = w_rch_free && w_rcp_free;
          CL_CPL:  s_ready = w_rch_free;
          default: s_ready = 1'b1;
        endcase
      end
      S_WR_PAY: s_ready = w_wr_free;
      S_RC_PAY: s_ready = w_rcp_free;
      default:  s_ready = 1'b1;
    endcase
  end

  assign w_hs   = s_valid && s_ready;
  assign w_tail = w_hs && (r_state != S_DROP) && !(w_idle && w_cls == CL_UNS);

  // FSM, output registers and counters; drain first, a same-cycle load wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_exp      <= '0;
      r_ar_v     <= 1'b0;  r_ar_d  <= '0;
      r_aw_v     <= 1'b0;  r_aw_d  <= '0;
      r_rch_v    <= 1'b0;  r_rch_d <= '0;
      r_wr_v     <= 1'b0;  r_wr_d  <= '0;  r_wr_last  <= 1'b0;
      r_rcp_v    <= 1'b0;  r_rcp_d <= '0;  r_rcp_last <= 1'b0;
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
      r_malf_cnt <= '0;
    end else begin
      r_err <= 1'b0;
      if (ar_hdr_ready) r_ar_v  <= 1'b0;
      if (aw_hdr_ready) r_aw_v  <= 1'b0;
      if (rc_hdr_ready) r_rch_v <= 1'b0;
      if (wr_pay_ready) r_wr_v  <= 1'b0;
      if (rc_pay_ready) r_rcp_v <= 1'b0;

      if (w_hs) begin
        case (r_state)
          S_IDLE: begin
            case (w_cls)
              CL_MRD: begin r_ar_v <= 1'b1; r_ar_d <= w_hdr; end
              CL_CPL: begin r_rch_v <= 1'b1; r_rch_d <= w_hdr; end
              CL_MWR: begin
                r_aw_v <= 1'b1; r_aw_d <= w_hdr;
                r_wr_v <= 1'b1; r_wr_d <= s_data; r_wr_last <= w_pay_last;
              end
              CL_CPLD: begin
                r_rch_v <= 1'b1; r_rch_d <= w_hdr;
                r_rcp_v <= 1'b1; r_rcp_d <= s_data; r_rcp_last <= w_pay_last;
              end
              default: begin
                if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
                if (!s_last) r_state <= S_DROP;
              end
            endcase
          end
          S_WR_PAY: begin
            r_wr_v <= 1'b1; r_wr_d <= s_data; r_wr_last <= w_pay_last;
          end
          S_RC_PAY: begin
            r_rcp_v <= 1'b1; r_rcp_d <= s_data; r_rcp_last <= w_pay_last;
          end
          default: if (s_last) r_state <= S_IDLE;
        endcase
      end

      if (w_tail) begin
        r_cnt   <= w_cnt_nxt;
        r_exp   <= w_exp_cur;
        r_state <= w_nxt_state;
        r_err   <= w_pay_err;
        if (w_pay_err && r_malf_cnt != '1) r_malf_cnt <= r_malf_cnt + 1'b1;
      end
    end
  end

  assign ar_hdr_valid  = r_ar_v;
  assign ar_hdr_data   = r_ar_d;
  assign aw_hdr_valid  = r_aw_v;
  assign aw_hdr_data   = r_aw_d;
  assign wr_pay_valid  = r_wr_v;
  assign wr_pay_data   = r_wr_d;
  assign wr_pay_last   = r_wr_last;
  assign rc_hdr_valid  = r_rch_v;
  assign rc_hdr_data   = r_rch_d;
  assign rc_pay_valid  = r_rcp_v;
  assign rc_pay_data   = r_rcp_d;
  assign rc_pay_last   = r_rcp_last;
  assign err_malformed = r_err;
  assign drop_cnt      = r_drop_cnt;
  assign malformed_cnt = r_malf_cnt;
endmodule
